// File: rtl/l2_bus_pkg.sv
// Shared definitions for the L2 line bus: line geometry, address field
// positions and the responder state encoding. Also imported by cache-group
// benches that drive or observe the bus.
package l2_bus_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned WORD_OFF_W     = 4;

  // Byte offset within a line occupies bus_addr[5:0]; line index follows.
  localparam int unsigned BYTE_OFF_LSB   = 0;
  localparam int unsigned BYTE_OFF_MSB   = 5;
  localparam int unsigned LINE_LSB       = BYTE_OFF_MSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } bus_state_e;

  function automatic logic is_beat_state(bus_state_e s);
    return (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/l2_bus_responder_line_store.sv
// Single-port word array backing the responder.
// Ports:
//   clk   - clock
//   we    - write enable, word written at the rising edge
//   addr  - word address {line, word}
//   wdata - write word
//   rdata - registered read word (one-cycle synchronous read)
// Contents are never cleared; power-up contents are undefined.
module line_store #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/l2_bus_responder.sv
// Memory-side responder for the L2 line bus. Serves 16-word line reads and
// writebacks from an internal word array after ACCESS_LATENCY wait cycles.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous, active-high; aborts any burst (memory kept)
//   bus_rreq  - line read request (wins over bus_wreq)
//   bus_wreq  - line write request
//   bus_addr  - byte address; line index = bus_addr[6 +: LINE_ADDR_W]
//   bus_wdata - write word for the current beat
//   bus_rdata - read word, zero outside read beats
//   bus_acc   - per-word beat strobe
//   bus_busy  - transaction in progress
module l2_bus_responder
  import l2_bus_pkg::*;
#(
  parameter int unsigned LINE_ADDR_W    = 8,
  parameter int unsigned ACCESS_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_rreq,
  input  logic        bus_wreq,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_acc,
  output logic        bus_busy
);

  localparam int unsigned STORE_AW = LINE_ADDR_W + WORD_OFF_W;
  localparam int unsigned WAIT_W   = (ACCESS_LATENCY < 2) ? 1 : $clog2(ACCESS_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ACCESS_LATENCY);

  bus_state_e             state, state_n;
  logic                   arm;
  logic                   is_read;
  logic [LINE_ADDR_W-1:0] line_q;
  logic [WORD_OFF_W-1:0]  word_cnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   accept;

  logic                   mem_we;
  logic [LINE_ADDR_W-1:0] mem_line;
  logic [WORD_OFF_W-1:0]  mem_word;
  logic [WORD_W-1:0]      mem_rdata;

  logic                   unused_addr_bits;
  assign unused_addr_bits = ^{bus_addr[31:LINE_LSB+LINE_ADDR_W],
                              bus_addr[BYTE_OFF_MSB:BYTE_OFF_LSB]};

  // A request only fires from IDLE after the bus has been seen idle once,
  // so a request held across a whole burst does not restart it.
  assign accept = (state == ST_IDLE) && arm && (bus_rreq || bus_wreq);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      arm      <= 1'b1;
      is_read  <= 1'b0;
      line_q   <= '0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        arm <= 1'b0;
      end else if (!bus_rreq && !bus_wreq) begin
        arm <= 1'b1;
      end
      if (accept) begin
        line_q   <= bus_addr[LINE_LSB +: LINE_ADDR_W];
        is_read  <= bus_rreq;
        word_cnt <= '0;
        wait_cnt <= WAIT_INIT;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end else if (is_beat_state(state)) begin
        word_cnt <= word_cnt + WORD_OFF_W'(1);
      end
    end
  end

  // The wait counter is loaded with the latency and the beat state is
  // entered on the edge where it would reach zero, giving exactly
  // ACCESS_LATENCY cycles of WAIT.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (ACCESS_LATENCY == 0) begin
            state_n = bus_rreq ? ST_READ : ST_WRITE;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_W'(1)) begin
          state_n = is_read ? ST_READ : ST_WRITE;
        end
      end
      ST_READ, ST_WRITE: begin
        if (word_cnt == '1) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Array address runs one word ahead of the read beat so the synchronous
  // read lands in the beat cycle. In IDLE the incoming address is used so a
  // zero-latency read has word 0 ready on its first beat.
  always_comb begin
    mem_we   = 1'b0;
    mem_line = line_q;
    mem_word = '0;
    unique case (state)
      ST_IDLE:  mem_line = bus_addr[LINE_LSB +: LINE_ADDR_W];
      ST_WAIT:  mem_word = '0;
      ST_READ:  mem_word = word_cnt + WORD_OFF_W'(1);
      ST_WRITE: begin
        mem_word = word_cnt;
        mem_we   = ~reset;
      end
      default:  mem_word = '0;
    endcase
  end

  line_store #(
    .ADDR_W (STORE_AW),
    .DATA_W (WORD_W)
  ) u_store (
    .clk   (clk),
    .we    (mem_we),
    .addr  ({mem_line, mem_word}),
    .wdata (bus_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    bus_busy  = (state != ST_IDLE);
    bus_acc   = is_beat_state(state);
    bus_rdata = (state == ST_READ) ? mem_rdata : '0;
  end

endmodule

// File: doc/l2_bus_responder.md
# l2_bus_responder

Memory-side responder for the L2 line bus: it answers line-fill reads and writeback writes issued by cache groups on `bus_rreq`/`bus_wreq`. Each transaction moves one 64-byte line, which is 16 words, in a fixed-length burst. Data is backed by an internal word array. The block serves as the memory endpoint in L2 integration and as the bus model in cache-group benches.

## Interface
- `LINE_ADDR_W`, default 8: line-index width; the array holds 2^LINE_ADDR_W lines.
- `ACCESS_LATENCY`, default 2: wait cycles between accept and the first data beat; 0 is legal.
- `clk` in 1: clock; all logic on rising edge. One clock domain.
- `reset` in 1: synchronous, active-high.
- `bus_rreq` in 1: line read (fill) request.
- `bus_wreq` in 1: line write (writeback) request.
- `bus_addr` in 32: byte address; bits [5:0] ignored; line index = bus_addr[6 +: LINE_ADDR_W]; higher bits ignored (aliasing).
- `bus_wdata` in 32: write word, held by the initiator until its beat is acknowledged.
- `bus_rdata` out 32: read word, valid only while `bus_acc`=1 in a read, else 0.
- `bus_acc` out 1: per-word beat strobe.
- `bus_busy` out 1: transaction in progress.

## Operation
- States are IDLE, WAIT, READ, WRITE.
- **Arm flag.** Set when `bus_rreq`=`bus_wreq`=0. Cleared on accept. Set by reset. A request is accepted only in IDLE with arm=1, so a held request never retriggers.
- **IDLE.** Accepting a request does the following:
  - Latches the line index and the direction. `bus_rreq` wins if both requests are high.
  - Clears the word counter (4 bits).
  - Sets the wait counter to `ACCESS_LATENCY`.
  - Moves to WAIT, or directly to READ/WRITE if the latency is 0.
- **WAIT.** Decrements the wait counter. At 0, goes to READ or WRITE.
- **READ.** For words 0..15 in order, drives `bus_acc`=1 and `bus_rdata`=mem[line][k], one word per cycle with no gaps.
- **WRITE.** Drives `bus_acc`=1 for 16 consecutive cycles.
  - At the edge closing beat k, `bus_wdata` is written to mem[line][k].
  - The initiator presents word 0 before the first beat and advances on each sampled `bus_acc`.
- **Burst end.** After word 15, the block goes to IDLE with `bus_acc` and `bus_busy` low.
- **Word counter.** Increments mod 16; the wrap to 0 coincides with the exit to IDLE.
- **Reset behaviour.**
  - Reset mid-burst aborts the transfer: next cycle is IDLE and all outputs are 0.
  - Memory contents are not cleared; words already written in an aborted write persist.
  - Memory content after power-up is undefined; benches preload it.
- **Ignored requests.** Requests while `bus_busy`=1 are ignored, and are not queued.

## Timing
- Reset values: `bus_acc`=0, `bus_busy`=0, `bus_rdata`=0, state IDLE, arm=1.
- Let request-sampling edge = E0 and L = `ACCESS_LATENCY`.
- `bus_busy` is 1 from cycle E0+1 through cycle E0+L+16. It is 0 from cycle E0+L+17.
- Beats occur at cycles E0+L+1 … E0+L+16, one per cycle.
- Minimum turnaround: the initiator drops its request, arm re-sets on the first low cycle, and a new request can be accepted on the following edge.
- All outputs are registered; no combinational path from inputs to outputs.
- The array read is synchronous. The read address is issued one cycle ahead of the beat, so `bus_rdata` aligns with `bus_acc`.

## Structure
- **Package `l2_bus_pkg`:**
  - `WORDS_PER_LINE`=16 and `LINE_BYTES`=64.
  - The state enum: IDLE, WAIT, READ, WRITE.
  - Word-offset width (4) and the byte-offset field [5:0].
  - Shared with cache-group benches.
- **Sub-module `line_store`:** single-port word array, depth 2^(LINE_ADDR_W+4), synchronous write, one-cycle synchronous read, address {line, word}.
- **Top-level:** FSM, counters, arm flag, output registers.

## Test plan
- **Write then read:** preload nothing; pulse `bus_wreq`, addr 0x0000_0140 (line 5), wdata 0xA000_0000+k per beat → 16 beats, `bus_busy` low at E0+19 (L=2). Then `bus_rreq` on the same line → `bus_rdata`=0xA000_0000..0xA000_000F on consecutive `bus_acc` cycles.
- **Latency sweep:** L=0 and L=5 → first `bus_acc` at E0+1 and E0+6 respectively; exactly 16 beats each.
- **Held request:** hold `bus_rreq` high for 40 cycles → exactly one burst; a second burst starts only after one low cycle.
- **Simultaneous requests:** `bus_rreq` and `bus_wreq` both high → read performed, memory unchanged. Requests raised mid-burst → ignored.
- **Aliasing and offset bits:** addr 0x0004_017C and 0x0000_0140 with L=8 bits → same line 5; byte offset 0x3C ignored and the burst starts at word 0.
- **Reset mid-write:** assert reset after beat 7 → outputs 0 next cycle; a readback shows words 0–7 new and 8–15 old.
